multicycle_control: RTL and testbench

//  Moore FSM that sequences the shared multi-cycle MIPS datapath (one memory, one ALU, IR, A/B/ALUOut regs).

---
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control.sv | 178 +++++++++++++++++
 tb/tb_multicycle_control.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer (master) and the shared MIPS datapath (slave).
// The master modport drives the datapath strobes and reads back the opcode, the ALU flag and memory status.
interface multicycle_control_if #(
    parameter int CNT_WIDTH = 32
);
    logic [5:0]           OP;
    logic                 Zero;
    logic                 MemReady;
    logic                 PCEn;
    logic                 IorD;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 IRWrite;
    logic                 RegDst;
    logic                 MemtoReg;
    logic                 RegWrite;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [2:0]           ALUOp;
    logic [1:0]           PCSource;
    logic                 InstrDone;
    logic                 Illegal;
    logic [CNT_WIDTH-1:0] InstrCount;
    logic [3:0]           State;

    modport master (
        input  OP, Zero, MemReady,
        output PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, Illegal, InstrCount, State
    );

    modport slave (
        output OP, Zero, MemReady,
        input  PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, Illegal, InstrCount, State
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the shared multi-cycle MIPS datapath: steps each instruction through
// fetch/decode/execute/memory/writeback, one state per clock, stalling on memory wait states.
module multicycle_control #(
    parameter int CNT_WIDTH       = 32,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_ALU_WB   = 4'd7,
        S_I_EXEC   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B, OP_BEQ = 6'h04, OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [2:0] ALU_ADD = 3'b100, ALU_OR = 3'b101, ALU_AND = 3'b110;
    localparam logic [2:0] ALU_SUB = 3'b001, ALU_FUNCT = 3'b111;

    state_e               state_q, state_d;
    logic [5:0]           op_q, op_d;
    logic                 illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic pc_en, ir_write, reg_write, mem_write, instr_done;

    // Outputs depend only on the current state and the latched opcode, except PCEn (Zero)
    // and the fetch/store handshakes that complete on MemReady.
    always_comb begin
        pc_en        = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        mem_write    = 1'b0;
        instr_done   = 1'b0;
        bus.IorD     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.ALUOp    = 3'b000;
        bus.PCSource = 2'b00;
        case (state_q)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = ALU_ADD;
                ir_write    = bus.MemReady;
                pc_en       = bus.MemReady;
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                bus.ALUOp   = ALU_ADD;
            end
            S_R_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALU_FUNCT;
            end
            S_I_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = (op_q == OP_ORI)  ? ALU_OR  :
                              (op_q == OP_ANDI) ? ALU_AND : ALU_ADD;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                bus.RegDst = (op_q == OP_RTYPE);
                instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = ALU_ADD;
            end
            S_MEM_RD: begin
                bus.IorD    = 1'b1;
                bus.MemRead = 1'b1;
            end
            S_MEM_WB: begin
                reg_write    = 1'b1;
                bus.MemtoReg = 1'b1;
                instr_done   = 1'b1;
            end
            S_MEM_WR: begin
                bus.IorD   = 1'b1;
                mem_write  = 1'b1;
                instr_done = bus.MemReady;
            end
            S_BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUOp    = ALU_SUB;
                bus.PCSource = 2'b01;
                pc_en        = (op_q == OP_BEQ) ? bus.Zero : ~bus.Zero;
                instr_done   = 1'b1;
            end
            S_JUMP: begin
                bus.PCSource = 2'b10;
                pc_en        = 1'b1;
                instr_done   = 1'b1;
            end
            default: ;
        endcase
    end

    // Architectural side effects are suppressed while reset is held so an interrupted
    // instruction never leaves a partial write behind.
    assign bus.PCEn       = pc_en & ~reset;
    assign bus.IRWrite    = ir_write & ~reset;
    assign bus.RegWrite   = reg_write & ~reset;
    assign bus.MemWrite   = mem_write & ~reset;
    assign bus.InstrDone  = instr_done & ~reset;
    assign bus.Illegal    = illegal_q;
    assign bus.InstrCount = cnt_q;
    assign bus.State      = state_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        cnt_d     = bus.InstrDone ? cnt_q + CNT_WIDTH'(1) : cnt_q;
        case (state_q)
            S_FETCH:  if (bus.MemReady) state_d = S_DECODE;
            S_DECODE: begin
                op_d = bus.OP;
                case (bus.OP)
                    OP_RTYPE:              state_d = S_R_EXEC;
                    OP_ADDI, OP_ORI, OP_ANDI: state_d = S_I_EXEC;
                    OP_LW, OP_SW:          state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:        state_d = S_BRANCH;
                    OP_J:                  state_d = S_JUMP;
                    default: begin
                        if (TRAP_ON_ILLEGAL) begin
                            state_d   = S_TRAP;
                            illegal_d = 1'b1;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                endcase
            end
            S_R_EXEC, S_I_EXEC: state_d = S_ALU_WB;
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (bus.MemReady) state_d = S_MEM_WB;
            S_MEM_WR:   if (bus.MemReady) state_d = S_FETCH;
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: an instruction-level reference model expands each
// opcode into its list of steps and predicts state, control strobes, retire pulse and counter.
module tb_multicycle_control;
    localparam int CW = 4;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic [1:0] pcsource;
    } ctrl_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    multicycle_control_if #(.CNT_WIDTH(CW)) bus ();

    multicycle_control #(.CNT_WIDTH(CW), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int m_seq[$];
    int m_idx = 0;
    int m_cnt = 0;
    bit m_ill = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Step lists use the documented state numbers; waits repeat steps 0, 3 and 5.
    task automatic build_steps(input logic [5:0] op);
        case (op)
            6'h00:               m_seq = '{0, 1, 6, 7};
            6'h08, 6'h0D, 6'h0C: m_seq = '{0, 1, 8, 7};
            6'h23:               m_seq = '{0, 1, 2, 3, 4};
            6'h2B:               m_seq = '{0, 1, 2, 5};
            6'h04, 6'h05:        m_seq = '{0, 1, 9};
            6'h02:               m_seq = '{0, 1, 10};
            default:             m_seq = '{0, 1, 11};
        endcase
    endtask

    task automatic expect_out(input int step, input logic [5:0] op, input logic z, input logic rdy,
                              output ctrl_t c, output logic done);
        c    = '0;
        done = 1'b0;
        case (step)
            0:  begin c.memread = 1; c.alusrcb = 2'b01; c.aluop = 3'b100; c.irwrite = rdy; c.pcen = rdy; end
            1:  begin c.alusrcb = 2'b11; c.aluop = 3'b100; end
            6:  begin c.alusrca = 1; c.alusrcb = 2'b00; c.aluop = 3'b111; end
            8:  begin
                    c.alusrca = 1; c.alusrcb = 2'b10;
                    c.aluop = (op == 6'h0D) ? 3'b101 : (op == 6'h0C) ? 3'b110 : 3'b100;
                end
            7:  begin c.regwrite = 1; c.regdst = (op == 6'h00); done = 1; end
            2:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.aluop = 3'b100; end
            3:  begin c.iord = 1; c.memread = 1; end
            4:  begin c.regwrite = 1; c.memtoreg = 1; done = 1; end
            5:  begin c.iord = 1; c.memwrite = 1; done = rdy; end
            9:  begin
                    c.alusrca = 1; c.aluop = 3'b001; c.pcsource = 2'b01;
                    c.pcen = (op == 6'h04) ? z : ~z; done = 1;
                end
            10: begin c.pcsource = 2'b10; c.pcen = 1; done = 1; end
            default: ;
        endcase
    endtask

    task automatic cycle(input logic rst, input logic [5:0] op, input logic z, input logic rdy);
        ctrl_t exp_c, got_c;
        logic  exp_done;
        int    cur;
        @(negedge clk);
        reset        = rst;
        bus.OP       = op;
        bus.Zero     = z;
        bus.MemReady = rdy;
        if (m_idx == 0) build_steps(op);
        cur = m_seq[m_idx];
        expect_out(cur, op, z, rdy, exp_c, exp_done);
        if (rst) begin
            exp_c.pcen = 0; exp_c.irwrite = 0; exp_c.regwrite = 0; exp_c.memwrite = 0; exp_done = 0;
        end
        #1;
        got_c = '{bus.PCEn, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
                  bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource};
        check("state", 32'(bus.State), 32'(cur));
        check("ctrl", 32'(got_c), 32'(exp_c));
        check("done", 32'(bus.InstrDone), 32'(exp_done));
        check("illegal", 32'(bus.Illegal), 32'(m_ill));
        check("count", 32'(bus.InstrCount), 32'(m_cnt));
        if (rst) begin
            m_idx = 0; m_cnt = 0; m_ill = 1'b0;
        end else begin
            if (exp_done) m_cnt = (m_cnt + 1) % (1 << CW);
            if (cur == 11) begin
            end else if ((cur == 0 || cur == 3 || cur == 5) && !rdy) begin
            end else begin
                m_idx++;
                if (m_idx == m_seq.size()) m_idx = 0;
                else if (m_seq[m_idx] == 11) m_ill = 1'b1;
            end
        end
    endtask

    // Runs one instruction to completion; fw/mw are wait cycles in fetch and memory steps,
    // rst_step asserts reset during the first cycle spent in that step.
    task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                             input int rst_step);
        int  budget = 0;
        int  trap = 0;
        bit  fin = 1'b0;
        int  cur;
        logic rdy;
        logic rst;
        while (!fin && budget < 60) begin
            if (m_idx == 0) build_steps(op);
            cur = m_seq[m_idx];
            rst = (cur == rst_step);
            if (cur == 0 && fw > 0) begin rdy = 0; fw--; end
            else if ((cur == 3 || cur == 5) && mw > 0) begin rdy = 0; mw--; end
            else if (cur == 0 || cur == 3 || cur == 5) rdy = 1;
            else rdy = 1'($urandom);
            cycle(rst, op, z, rdy);
            budget++;
            if (rst) fin = 1'b1;
            else if (cur == 11) begin
                trap++;
                if (trap >= 3) fin = 1'b1;
            end else if (m_idx == 0 && cur != 0) fin = 1'b1;
        end
        if (!fin) check("budget", 32'(budget), 32'(0));
    endtask

    logic [5:0] legal_ops [9] = '{6'h00, 6'h08, 6'h0D, 6'h0C, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};

    initial begin
        bus.OP = '0; bus.Zero = 1'b0; bus.MemReady = 1'b1;
        @(posedge clk);
        cycle(1'b1, 6'h00, 1'b0, 1'b1);
        run_instr(6'h00, 1'b0, 0, 0, -1);
        run_instr(6'h23, 1'b0, 2, 2, -1);
        run_instr(6'h04, 1'b1, 0, 0, -1);
        run_instr(6'h05, 1'b1, 0, 0, -1);
        run_instr(6'h2B, 1'b0, 1, 1, -1);
        run_instr(6'h3F, 1'b0, 0, 0, -1);
        cycle(1'b1, 6'h3F, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) run_instr(6'h02, 1'($urandom), 0, 0, -1);
        run_instr(6'h2B, 1'b0, 0, 0, 5);
        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            int r = int'($urandom_range(0, 99));
            if (r < 4) begin
                op = (r < 2) ? 6'h3F : 6'h11;
                run_instr(op, 1'b0, 0, 0, -1);
                cycle(1'b1, op, 1'b0, 1'($urandom));
            end else begin
                op = legal_ops[$urandom_range(0, 8)];
                run_instr(op, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                          (r < 7) ? int'($urandom_range(0, 10)) : -1);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
